nes_joypad_port: RTL and testbench
==================================

# nes_joypad_port

Emulates one NES controller port register ($4016 bit 0) on top of the parallel button byte from the gamepad sampler. It captures each completed poll, filters impossible D-pad combinations, ages out stale data when the pad stops responding, and serves the bits to the CPU core through the standard strobe/serial-read protocol. It sits between the gamepad sampler and the CPU bus decode.

## Interface
Parameters:
- STALE_CYCLES, 1350000: cycles without a fresh capture (50 ms at 27 MHz) before the pad is declared disconnected.
- TURBO_DIV, 450000: turbo phase toggle period in cycles. Only used with NES_JOYPAD_TURBO_EN.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_button_state  in  8  {Right,Left,Down,Up,Start,Select,B,A}, bit0=A; 1=pressed.
- i_data_available  in  1  level, high while i_button_state is valid; multi-cycle.
- i_strobe_we  in  1  one-cycle pulse: CPU write to $4016.
- i_strobe_data  in  1  bit 0 of the written byte.
- i_read  in  1  one-cycle pulse: CPU read of this port.
- i_turbo_a, i_turbo_b  in  1  turbo enables. Ignored without the macro.
- o_read_data  out  1  serial bit presented to CPU D0.
- o_snapshot  out  8  filtered captured buttons (debug/OSD).
- o_connected  out  1  fresh capture within STALE_CYCLES.

## Operation
- Capture: avail_q is a registered copy of i_data_available. A rise is i_data_available & ~avail_q. On a rise, the snapshot loads the SOCD-filtered i_button_state, the stale counter clears, and o_connected goes to 1. Holding i_data_available high causes no further captures.
- SOCD filter, applied at capture:
  - Up&Down both set: clear both.
  - Left&Right both set: clear both.
  - Other bits pass unchanged.
- Staleness: the stale counter increments every cycle and saturates at STALE_CYCLES. On reaching STALE_CYCLES, the snapshot becomes 8'h00 and o_connected goes to 0. A capture in the same cycle wins.
- Effective buttons = snapshot, with turbo masking applied to bits 0 and 1 when the macro is enabled.
- Port state machine, with an 8-bit shreg and a 4-bit count (0..8):
  - STROBE (strobe=1): every cycle shreg ← effective and count ← 0. o_read_data = shreg[0]. Reads do not shift.
  - SHIFT (strobe=0, count<8): i_read returns the current shreg[0], then shreg ← {1'b1, shreg[7:1]} and count++.
  - EXHAUSTED (count==8): o_read_data = 1. Reads have no effect.
- Strobe writes:
  - i_strobe_we with data 1: enter STROBE.
  - i_strobe_we with data 0: load shreg ← effective, count ← 0, strobe ← 0, enter SHIFT.
- Simultaneous i_strobe_we and i_read: the write takes effect and the shift is suppressed. The read sees o_read_data from before the edge.
- Simultaneous capture and reload: the reload uses the pre-edge snapshot. The new snapshot is used from the next cycle.
- Reset mid-sequence aborts the read immediately. All state returns to its reset values.

## Timing
- Reset values:
  - o_read_data = 0 (shreg 8'h00)
  - o_snapshot = 8'h00
  - o_connected = 0
  - strobe = 0, count = 0, avail_q = 0, stale counter = 0, turbo phase = 0
- Capture latency: i_data_available sampled high (with avail_q low) at edge k → o_snapshot and o_connected updated after edge k (visible in cycle k+1).
- o_read_data is driven from registers only (shreg[0], or constant 1 when count==8). It changes only at clock edges, one edge after the i_read or i_strobe_we that caused the change.
- In STROBE, a capture at edge k is reflected on o_read_data after edge k+1.
- Staleness: STALE_CYCLES cycles after the last capture edge, o_connected falls on that edge.

## Configuration
- NES_JOYPAD_TURBO_EN defined:
  - Adds a TURBO_DIV cycle counter that toggles phase on wrap.
  - Effective bit0 = snapshot[0] & (~i_turbo_a | phase).
  - Effective bit1 = snapshot[1] & (~i_turbo_b | phase).
  - Phase resets to 0, so held turbo buttons read released for the first TURBO_DIV cycles.
- Undefined: no turbo counter, i_turbo_a and i_turbo_b are ignored, and effective = snapshot.

## Test plan
- Capture/read: button byte 8'h09 (A+Start) with i_data_available high for 5 cycles; write 1 then 0; 10 reads → 1,0,0,1,0,0,0,0,1,1. Only one capture occurs.
- SOCD: capture 8'hF0 → o_snapshot = 8'h00. Capture 8'h31 → o_snapshot = 8'h01.
- Strobe held: strobe=1, button byte 8'h01, 3 reads → 1,1,1. Change to 8'h00 via a new capture → o_read_data = 0 two cycles after the capture edge.
- Stale: capture 8'hFF (filtered to 8'h0F), then no captures for STALE_CYCLES → o_connected 1→0 and o_snapshot = 8'h00. Subsequent reads return 0×8, then 1.
- Collisions: i_strobe_we(0) and i_read in the same cycle → no shift and count = 0. Reset after 3 reads → o_read_data = 0, o_connected = 0.
- Turbo (macro on, TURBO_DIV=4): A held with i_turbo_a=1, strobe=1 → o_read_data alternates four cycles 0, four cycles 1, lagging the phase by one cycle. With the macro off, A reads constant 1.

Source files
------------

// File: rtl/nes_joypad_port.sv
// NES controller port ($4016 bit 0): captures sampler polls, filters SOCD, ages out stale data.
// Optional turbo masking on A/B is enabled by defining NES_JOYPAD_TURBO_EN.
module nes_joypad_port #(
  parameter int STALE_CYCLES = 1350000,
  parameter int TURBO_DIV    = 450000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_button_state,
  input  logic       i_data_available,
  input  logic       i_strobe_we,
  input  logic       i_strobe_data,
  input  logic       i_read,
  input  logic       i_turbo_a,
  input  logic       i_turbo_b,
  output logic       o_read_data,
  output logic [7:0] o_snapshot,
  output logic       o_connected
);

  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);

  localparam logic [1:0] ST_SHIFT     = 2'd0;
  localparam logic [1:0] ST_STROBE    = 2'd1;
  localparam logic [1:0] ST_EXHAUSTED = 2'd2;

  logic               avail_q;
  logic               capture;
  logic [7:0]         filtered;
  logic [7:0]         snapshot;
  logic [7:0]         effective;
  logic [STALE_W-1:0] stale_cnt;
  logic               connected;
  logic [1:0]         state;
  logic [3:0]         count;
  logic [7:0]         shreg;

  assign capture = i_data_available & ~avail_q;

  // Opposing D-pad directions cancel each other out.
  always_comb begin
    filtered = i_button_state;
    if (i_button_state[4] & i_button_state[5]) filtered[5:4] = 2'b00;
    if (i_button_state[6] & i_button_state[7]) filtered[7:6] = 2'b00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) avail_q <= 1'b0;
    else       avail_q <= i_data_available;
  end

  // A capture always beats the staleness timeout landing on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      snapshot  <= 8'h00;
      stale_cnt <= '0;
      connected <= 1'b0;
    end else if (capture) begin
      snapshot  <= filtered;
      stale_cnt <= '0;
      connected <= 1'b1;
    end else if (stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + 1'b1;
      if (stale_cnt == STALE_LAST) begin
        snapshot  <= 8'h00;
        connected <= 1'b0;
      end
    end
  end

`ifdef NES_JOYPAD_TURBO_EN
  localparam int TURBO_W = $clog2(TURBO_DIV + 1);
  localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_DIV - 1);

  logic [TURBO_W-1:0] turbo_cnt;
  logic               phase;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      turbo_cnt <= '0;
      phase     <= 1'b0;
    end else if (turbo_cnt == TURBO_LAST) begin
      turbo_cnt <= '0;
      phase     <= ~phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  assign effective = {snapshot[7:2],
                      snapshot[1] & (~i_turbo_b | phase),
                      snapshot[0] & (~i_turbo_a | phase)};
`else
  logic unused_turbo;
  assign unused_turbo = i_turbo_a ^ i_turbo_b ^ (TURBO_DIV == 0);
  assign effective    = snapshot;
`endif

  // Reloads always sample the registered snapshot, so a coincident capture shows up one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_SHIFT;
      count <= 4'd0;
      shreg <= 8'h00;
    end else if (i_strobe_we) begin
      state <= i_strobe_data ? ST_STROBE : ST_SHIFT;
      count <= 4'd0;
      shreg <= effective;
    end else begin
      case (state)
        ST_STROBE: begin
          count <= 4'd0;
          shreg <= effective;
        end
        ST_SHIFT: begin
          if (i_read) begin
            shreg <= {1'b1, shreg[7:1]};
            count <= count + 4'd1;
            if (count == 4'd7) state <= ST_EXHAUSTED;
          end
        end
        ST_EXHAUSTED: begin
        end
        default: state <= ST_SHIFT;
      endcase
    end
  end

  assign o_read_data = (state == ST_EXHAUSTED) ? 1'b1 : shreg[0];
  assign o_snapshot  = snapshot;
  assign o_connected = connected;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port: directed test-plan steps plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_nes_joypad_port;

  localparam int STALE = 60;
  localparam int TDIV  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic       avail;
  logic       we;
  logic       wdata;
  logic       rd;
  logic       turbo_a;
  logic       turbo_b;
  logic       read_data;
  logic [7:0] snapshot;
  logic       connected;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: serial port as a queue of bits still to be read.
  bit         m_avail_q;
  logic [7:0] m_snap;
  bit         m_conn;
  int         m_age;
  bit         m_strobe;
  bit         m_bits[$];
  int         m_cycles;

  always #5 clk = ~clk;

  nes_joypad_port #(
    .STALE_CYCLES(STALE),
    .TURBO_DIV(TDIV)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_button_state(btn),
    .i_data_available(avail),
    .i_strobe_we(we),
    .i_strobe_data(wdata),
    .i_read(rd),
    .i_turbo_a(turbo_a),
    .i_turbo_b(turbo_b),
    .o_read_data(read_data),
    .o_snapshot(snapshot),
    .o_connected(connected)
  );

  function automatic logic [7:0] socd(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[4] && b[5]) r[5:4] = 2'b00;
    if (b[6] && b[7]) r[7:6] = 2'b00;
    return r;
  endfunction

  function automatic logic [7:0] model_eff();
    logic [7:0] e;
    e = m_snap;
`ifdef NES_JOYPAD_TURBO_EN
    begin
      bit ph;
      ph = ((m_cycles / TDIV) % 2) == 1;
      if (turbo_a && !ph) e[0] = 1'b0;
      if (turbo_b && !ph) e[1] = 1'b0;
    end
`endif
    return e;
  endfunction

  function automatic bit model_out();
    if (m_bits.size() == 0) return 1'b1;
    return m_bits[0];
  endfunction

  task automatic model_reset();
    m_avail_q = 1'b0;
    m_snap    = 8'h00;
    m_conn    = 1'b0;
    m_age     = 0;
    m_strobe  = 1'b0;
    m_cycles  = 0;
    m_bits.delete();
    for (int i = 0; i < 8; i++) m_bits.push_back(1'b0);
  endtask

  task automatic load_bits(input logic [7:0] e);
    m_bits.delete();
    for (int i = 0; i < 8; i++) m_bits.push_back(e[i]);
  endtask

  // Advance the model with the current inputs, clock the DUT, then drop one-cycle pulses.
  task automatic applyStimulus();
    logic [7:0] e;
    e = model_eff();
    if (rst) begin
      model_reset();
    end else begin
      if (we) begin
        load_bits(e);
        m_strobe = wdata;
      end else if (m_strobe) begin
        load_bits(e);
      end else if (rd && m_bits.size() > 0) begin
        void'(m_bits.pop_front());
      end
      if (avail && !m_avail_q) begin
        m_snap = socd(btn);
        m_age  = 0;
        m_conn = 1'b1;
      end else if (m_age < STALE) begin
        m_age++;
        if (m_age == STALE) begin
          m_snap = 8'h00;
          m_conn = 1'b0;
        end
      end
      m_avail_q = avail;
      m_cycles++;
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    we = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "/read"}, {7'b0, read_data}, {7'b0, model_out()});
    checkOutput({tag, "/snap"}, snapshot, m_snap);
    checkOutput({tag, "/conn"}, {7'b0, connected}, {7'b0, m_conn});
  endtask

  task automatic step_check(input string tag);
    applyStimulus();
    checkModel(tag);
  endtask

  initial begin
    logic [9:0] exp_seq;
    exp_seq = 10'b11_0000_1001;
    rst = 1'b1; btn = 8'h00; avail = 1'b0; we = 1'b0; wdata = 1'b0;
    rd = 1'b0; turbo_a = 1'b0; turbo_b = 1'b0;
    model_reset();
    #1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkModel("reset");
    checkOutput("reset_read", {7'b0, read_data}, 8'h00);
    checkOutput("reset_snap", snapshot, 8'h00);
    checkOutput("reset_conn", {7'b0, connected}, 8'h00);

    $display("[TB] capture and serial read");
    btn = 8'h09; avail = 1'b1;
    for (int i = 0; i < 5; i++) step_check("cap_hold");
    avail = 1'b0;
    step_check("cap_drop");
    checkOutput("cap_snap", snapshot, 8'h09);
    checkOutput("cap_conn", {7'b0, connected}, 8'h01);
    we = 1'b1; wdata = 1'b1; step_check("strobe_hi");
    we = 1'b1; wdata = 1'b0; step_check("strobe_lo");
    for (int i = 0; i < 10; i++) begin
      checkOutput("read_seq", {7'b0, read_data}, {7'b0, exp_seq[i]});
      rd = 1'b1;
      step_check("read_seq_model");
    end

    $display("[TB] SOCD filter");
    btn = 8'hF0; avail = 1'b1; step_check("socd_f0");
    checkOutput("socd_f0_snap", snapshot, 8'h00);
    avail = 1'b0; step_check("socd_gap");
    btn = 8'h31; avail = 1'b1; step_check("socd_31");
    checkOutput("socd_31_snap", snapshot, 8'h01);
    avail = 1'b0; step_check("socd_gap");

    $display("[TB] strobe held");
    btn = 8'h01; avail = 1'b1; step_check("sh_cap");
    avail = 1'b0;
    we = 1'b1; wdata = 1'b1; step_check("sh_strobe");
    for (int i = 0; i < 3; i++) begin
      checkOutput("sh_read", {7'b0, read_data}, 8'h01);
      rd = 1'b1;
      step_check("sh_read_model");
    end
    btn = 8'h00; avail = 1'b1; step_check("sh_cap0");
    checkOutput("sh_cap0_lag", {7'b0, read_data}, 8'h01);
    avail = 1'b0; step_check("sh_cap0_next");
    checkOutput("sh_cap0_seen", {7'b0, read_data}, 8'h00);
    we = 1'b1; wdata = 1'b0; step_check("sh_release");

    $display("[TB] staleness");
    btn = 8'hFF; avail = 1'b1; step_check("st_cap");
    checkOutput("st_snap", snapshot, 8'h0F);
    checkOutput("st_conn", {7'b0, connected}, 8'h01);
    avail = 1'b0;
    for (int i = 1; i < STALE; i++) begin
      step_check("st_wait");
      checkOutput("st_still_conn", {7'b0, connected}, 8'h01);
    end
    step_check("st_edge");
    checkOutput("st_disc", {7'b0, connected}, 8'h00);
    checkOutput("st_cleared", snapshot, 8'h00);
    we = 1'b1; wdata = 1'b1; step_check("st_strobe");
    we = 1'b1; wdata = 1'b0; step_check("st_latch");
    for (int i = 0; i < 9; i++) begin
      checkOutput("st_read", {7'b0, read_data}, (i < 8) ? 8'h00 : 8'h01);
      rd = 1'b1;
      step_check("st_read_model");
    end

    $display("[TB] collisions");
    btn = 8'h01; avail = 1'b1; step_check("co_cap");
    avail = 1'b0;
    we = 1'b1; wdata = 1'b1; step_check("co_strobe");
    we = 1'b1; wdata = 1'b0; rd = 1'b1; step_check("co_both");
    checkOutput("co_noshift", {7'b0, read_data}, 8'h01);
    rd = 1'b1; step_check("co_read1");
    checkOutput("co_shifted", {7'b0, read_data}, 8'h00);
    rd = 1'b1; step_check("co_read2");
    rd = 1'b1; step_check("co_read3");
    rst = 1'b1; step_check("co_reset");
    rst = 1'b0;
    checkOutput("co_rst_read", {7'b0, read_data}, 8'h00);
    checkOutput("co_rst_conn", {7'b0, connected}, 8'h00);
    checkOutput("co_rst_snap", snapshot, 8'h00);

    $display("[TB] turbo");
    btn = 8'h01; avail = 1'b1; step_check("tu_cap");
    avail = 1'b0; turbo_a = 1'b1;
    we = 1'b1; wdata = 1'b1; step_check("tu_strobe");
    for (int i = 0; i < 12; i++) begin
      step_check("tu_cycle");
`ifndef NES_JOYPAD_TURBO_EN
      checkOutput("tu_off_const", {7'b0, read_data}, 8'h01);
`endif
    end
    turbo_a = 1'b0;
    we = 1'b1; wdata = 1'b0; step_check("tu_release");

    $display("[TB] randomized traffic");
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 300; i++) begin
        rst     = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 3) == 0) avail = ~avail;
        if (!avail) btn = 8'($urandom);
        we      = ($urandom_range(0, 9) == 0);
        wdata   = 1'($urandom);
        rd      = ($urandom_range(0, 2) == 0);
        turbo_a = 1'($urandom);
        turbo_b = 1'($urandom);
        step_check("rand");
      end
      rst = 1'b0; avail = 1'b0;
      for (int i = 0; i < STALE + 10; i++) begin
        rd = ($urandom_range(0, 1) == 0);
        step_check("rand_idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
